// File: rtl/imem_dmem_arbiter.sv
// ============================================================================
// Module   : imem_dmem_arbiter
// Purpose  : Shares one single-port synchronous memory between the instruction
//            fetch and load/store ports. Data has priority; the instruction
//            side is forced to win after MAX_WAIT consecutive losses.
//            Optional macro ARB_PERF_CNT_EN adds conflict/starvation counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_dmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                m_en,
  output logic                m_we,
  output logic [DATA_W/8-1:0] m_be,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic [DATA_W-1:0]   m_rdata
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]         conflict_cnt,
  output logic [31:0]         starve_cnt
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_I_RD = 2'd1;
  localparam logic [1:0] ST_D_RD = 2'd2;
  localparam logic [1:0] ST_D_WR = 2'd3;

  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  logic [1:0] resp_state;
  logic [1:0] resp_next;
  logic [3:0] wait_cnt;
  logic       i_req_q;
  logic       d_req_q;
  logic       force_i;

  // Requests are masked while reset is held so every output reads as 0.
  assign i_req_q = i_req & rst;
  assign d_req_q = d_req & rst;
  assign force_i = (wait_cnt == WAIT_LIMIT);

  always_comb begin
    i_gnt = i_req_q & (~d_req_q | force_i);
    d_gnt = d_req_q & ~i_gnt;
    m_en  = i_gnt | d_gnt;
  end

  always_comb begin
    m_we    = 1'b0;
    m_be    = '0;
    m_addr  = '0;
    m_wdata = '0;
    if (i_gnt) begin
      m_be   = '1;
      m_addr = i_addr;
    end else if (d_gnt) begin
      m_we    = d_we;
      m_be    = d_be;
      m_addr  = d_addr;
      m_wdata = d_wdata;
    end
  end

  always_comb begin
    resp_next = ST_IDLE;
    if (i_gnt)
      resp_next = ST_I_RD;
    else if (d_gnt)
      resp_next = d_we ? ST_D_WR : ST_D_RD;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_state <= ST_IDLE;
      wait_cnt   <= 4'd0;
    end else begin
      resp_state <= resp_next;
      if (!i_req_q || i_gnt)
        wait_cnt <= 4'd0;
      else if (d_gnt && !force_i)
        wait_cnt <= wait_cnt + 4'd1;
    end
  end

  always_comb begin
    i_rvalid = 1'b0;
    i_rdata  = '0;
    d_rvalid = 1'b0;
    d_rdata  = '0;
    case (resp_state)
      ST_I_RD: begin
        i_rvalid = 1'b1;
        i_rdata  = m_rdata;
      end
      ST_D_RD: begin
        d_rvalid = 1'b1;
        d_rdata  = m_rdata;
      end
      ST_D_WR: d_rvalid = 1'b1;
      default: ;
    endcase
  end

`ifdef ARB_PERF_CNT_EN
  // A starvation event is an instruction win that beat a pending data request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conflict_cnt <= 32'd0;
      starve_cnt   <= 32'd0;
    end else begin
      if (i_req_q && d_req_q)
        conflict_cnt <= conflict_cnt + 32'd1;
      if (i_gnt && d_req_q)
        starve_cnt <= starve_cnt + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_imem_dmem_arbiter.sv
// ============================================================================
// Module   : tb_imem_dmem_arbiter
// Purpose  : Directed self-checking bench for imem_dmem_arbiter with a
//            byte-enabled 1-cycle-latency memory model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_dmem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt, i_rvalid;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req, d_we;
  logic [3:0]        d_be;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt, d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              m_en, m_we;
  logic [3:0]        m_be;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;
`ifdef ARB_PERF_CNT_EN
  logic [31:0]       conflict_cnt, starve_cnt;
`endif

  int tests = 0;
  int fails = 0;

  imem_dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata)
`ifdef ARB_PERF_CNT_EN
    , .conflict_cnt(conflict_cnt), .starve_cnt(starve_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Memory model: word-addressed, byte-enabled writes, registered read data.
  logic [31:0] mem [0:4095];
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    mem[12'h020] = 32'h00500093;
    m_rdata = 32'h0;
  end
  always @(posedge clk) begin
    if (m_en && m_we) begin
      for (int b = 0; b < 4; b++)
        if (m_be[b]) mem[m_addr[13:2]][b*8 +: 8] <= m_wdata[b*8 +: 8];
    end else if (m_en) begin
      m_rdata <= mem[m_addr[13:2]];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_i, prev_i, prev_d;

    // Reset with a request pending: everything must stay 0.
    rst = 1'b0; i_req = 1'b1; i_addr = 32'h80;
    d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'h40; d_wdata = 32'h1234;
    repeat (2) @(negedge clk);
    chk("rst_i_gnt", 64'(i_gnt), 64'd0);
    chk("rst_d_gnt", 64'(d_gnt), 64'd0);
    chk("rst_m_en", 64'(m_en), 64'd0);
    chk("rst_m_bus", 64'({m_we, m_be, m_addr, m_wdata}), 64'd0);
    chk("rst_rvalid", 64'({i_rvalid, d_rvalid}), 64'd0);
    chk("rst_rdata", 64'(i_rdata | d_rdata), 64'd0);
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_wdata = 32'h0;
    rst = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("idle_m_en", 64'(m_en), 64'd0);
      chk("idle_rvalid", 64'({i_rvalid, d_rvalid, i_gnt, d_gnt}), 64'd0);
    end

    // Single instruction fetch.
    i_req = 1'b1; i_addr = 32'h80;
    #1;
    chk("if_i_gnt", 64'(i_gnt), 64'd1);
    chk("if_d_gnt", 64'(d_gnt), 64'd0);
    chk("if_m_addr", 64'(m_addr), 64'h80);
    chk("if_m_we_be", 64'({m_en, m_we, m_be}), 64'b1_0_1111);
    chk("if_m_wdata", 64'(m_wdata), 64'd0);
    @(negedge clk);
    i_req = 1'b0;
    #1;
    chk("if_i_rvalid", 64'(i_rvalid), 64'd1);
    chk("if_i_rdata", 64'(i_rdata), 64'h00500093);
    chk("if_d_rvalid", 64'(d_rvalid), 64'd0);

    // Data write then read of the same word.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1000; d_wdata = 32'hDEADBEEF; d_be = 4'b0011;
    #1;
    chk("wr_d_gnt", 64'({i_gnt, d_gnt}), 64'b01);
    chk("wr_m_ctl", 64'({m_en, m_we, m_be}), 64'b1_1_0011);
    chk("wr_m_addr", 64'(m_addr), 64'h1000);
    chk("wr_m_wdata", 64'(m_wdata), 64'hDEADBEEF);
    @(negedge clk);
    chk("wr_d_rvalid", 64'(d_rvalid), 64'd1);
    chk("wr_d_rdata", 64'(d_rdata), 64'd0);
    chk("wr_i_rvalid", 64'(i_rvalid), 64'd0);
    d_we = 1'b0; d_wdata = 32'h0; d_be = 4'hF;
    #1;
    chk("rd_m_we", 64'({m_en, m_we}), 64'b10);
    @(negedge clk);
    d_req = 1'b0;
    chk("rd_d_rvalid", 64'(d_rvalid), 64'd1);
    chk("rd_d_rdata", 64'(d_rdata), 64'h0000BEEF);

    // Both requesters held: D,D,D,D,I repeating, responses follow grants.
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h80; d_req = 1'b1; d_addr = 32'h1000;
    prev_i = 1'b0; prev_d = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      exp_i = ((k % 5) == 4);
      chk("dual_i_gnt", 64'(i_gnt), 64'(exp_i));
      chk("dual_d_gnt", 64'(d_gnt), 64'(!exp_i));
      chk("dual_i_rvalid", 64'(i_rvalid), 64'(prev_i));
      chk("dual_d_rvalid", 64'(d_rvalid), 64'(prev_d));
      chk("dual_rdata", 64'(i_rdata | d_rdata),
          prev_i ? 64'h00500093 : (prev_d ? 64'h0000BEEF : 64'h0));
      prev_i = exp_i; prev_d = !exp_i;
    end
    @(negedge clk);
    i_req = 1'b0; d_req = 1'b0;
`ifdef ARB_PERF_CNT_EN
    chk("perf_conflict", 64'(conflict_cnt), 64'd20);
    chk("perf_starve", 64'(starve_cnt), 64'd4);
`endif

    // Alternating single-cycle grants I,D,I,D with reads.
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      i_req = (k == 0 || k == 2);
      d_req = (k == 1 || k == 3);
      d_we = 1'b0;
      #1;
      if (k < 4) chk("alt_gnt", 64'({i_gnt, d_gnt}), (k % 2 == 0) ? 64'b10 : 64'b01);
      chk("alt_rvalid", 64'({i_rvalid, d_rvalid}),
          (k == 0) ? 64'b00 : ((k % 2 == 1) ? 64'b10 : 64'b01));
      if (k > 0) chk("alt_rdata", 64'(i_rvalid ? i_rdata : d_rdata),
                     (k % 2 == 1) ? 64'h00500093 : 64'h0000BEEF);
      @(negedge clk);
    end
    i_req = 1'b0; d_req = 1'b0;

    // Reset while an instruction response is outstanding.
    @(negedge clk);
    i_req = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_i_rvalid", 64'(i_rvalid), 64'd0);
    @(negedge clk);
    i_req = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_i_rvalid", 64'({i_rvalid, d_rvalid}), 64'd0);
    chk("post_rst_rdata", 64'(i_rdata), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
